// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - push-button synchroniser, debouncer, auto-repeat and per-frame event delivery
module key_conditioner #(
    parameter int          DEBOUNCE_CYCLES = 250000,
    parameter int          REPEAT_DELAY    = 7500000,
    parameter int          REPEAT_RATE     = 2500000,
    parameter logic [3:0]  REPEAT_MASK     = 4'b1110
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic [3:0] raw_keys,
    input  logic       draw_finish,
    output logic [3:0] op_keys,
    output logic [3:0] keys_held
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_t;

    logic [3:0]    r_s1;
    logic [3:0]    r_s2;
    logic [3:0]    r_deb;
    logic [3:0]    r_deb_d;
    logic [DW-1:0] r_dcnt [4];
    rpt_state_t    r_state [4];
    logic [RW-1:0] r_rcnt [4];
    logic [3:0]    r_pending;
    logic [3:0]    r_op;

    logic [3:0]    w_press;
    logic [3:0]    w_repeat;
    logic [3:0]    w_event;

    // Two-stage synchroniser for the asynchronous button pins
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= raw_keys;
            r_s2 <= r_s1;
        end
    end

    // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_deb   <= '0;
            r_deb_d <= '0;
            for (int i = 0; i < 4; i++) r_dcnt[i] <= '0;
        end else begin
            r_deb_d <= r_deb;
            for (int i = 0; i < 4; i++) begin
                if (r_s2[i] == r_deb[i]) begin
                    r_dcnt[i] <= '0;
                end else if (r_dcnt[i] == DEB_LAST) begin
                    r_deb[i]  <= r_s2[i];
                    r_dcnt[i] <= '0;
                end else begin
                    r_dcnt[i] <= r_dcnt[i] + 1'b1;
                end
            end
        end
    end

    // A press is the first cycle the debounced level reads high
    assign w_press = r_deb & ~r_deb_d;

    // Auto-repeat FSM per key: wait the initial delay, then fire at the repeat rate while held
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_state[i] <= ST_IDLE;
                r_rcnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!REPEAT_MASK[i] || !r_deb[i]) begin
                    r_state[i] <= ST_IDLE;
                    r_rcnt[i]  <= '0;
                end else begin
                    case (r_state[i])
                        ST_IDLE: begin
                            if (w_press[i]) begin
                                r_state[i] <= ST_DELAY;
                                r_rcnt[i]  <= '0;
                            end
                        end
                        ST_DELAY: begin
                            if (r_rcnt[i] == DELAY_LAST) begin
                                r_state[i] <= ST_REPEAT;
                                r_rcnt[i]  <= '0;
                            end else begin
                                r_rcnt[i]  <= r_rcnt[i] + 1'b1;
                            end
                        end
                        ST_REPEAT: begin
                            if (r_rcnt[i] == RATE_LAST) r_rcnt[i] <= '0;
                            else                        r_rcnt[i] <= r_rcnt[i] + 1'b1;
                        end
                        default: begin
                            r_state[i] <= ST_IDLE;
                            r_rcnt[i]  <= '0;
                        end
                    endcase
                end
            end
        end
    end

    // Repeat events fire on the terminal count of the current phase, only while the key is held
    always_comb begin
        w_repeat = '0;
        for (int i = 0; i < 4; i++) begin
            w_repeat[i] = REPEAT_MASK[i] && r_deb[i] &&
                          (((r_state[i] == ST_DELAY)  && (r_rcnt[i] == DELAY_LAST)) ||
                           ((r_state[i] == ST_REPEAT) && (r_rcnt[i] == RATE_LAST)));
        end
    end

    assign w_event = w_press | w_repeat;

    // Accumulate events between frames and deliver them as a one-cycle pulse after draw_finish
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_pending <= '0;
            r_op      <= '0;
        end else if (draw_finish) begin
            r_op      <= r_pending | w_event;
            r_pending <= '0;
        end else begin
            r_op      <= '0;
            r_pending <= r_pending | w_event;
        end
    end

    assign op_keys   = r_op;
    assign keys_held = r_deb;

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - randomized and directed bench for key_conditioner against a behavioural model
module tb_key_conditioner;

    localparam int         DEB  = 4;
    localparam int         RD   = 10;
    localparam int         RR   = 5;
    localparam logic [3:0] MASK = 4'b1110;

    logic       vga_clk = 1'b0;
    logic       rst     = 1'b1;
    logic [3:0] raw     = 4'b0000;
    logic       draw    = 1'b0;
    logic [3:0] op_keys;
    logic [3:0] keys_held;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: each key's debounced level, the cycle it last went high, and a run of differing samples
    int         cyc    = 0;
    logic [3:0] m_s1   = '0;
    logic [3:0] m_s2   = '0;
    logic [3:0] m_deb  = '0;
    logic [3:0] m_pend = '0;
    logic [3:0] m_op   = '0;
    int         m_run  [4] = '{0, 0, 0, 0};
    int         m_rise [4] = '{0, 0, 0, 0};

    key_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR),
        .REPEAT_MASK    (MASK)
    ) dut (
        .vga_clk    (vga_clk),
        .reset      (rst),
        .raw_keys   (raw),
        .draw_finish(draw),
        .op_keys    (op_keys),
        .keys_held  (keys_held)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic model_edge();
        logic [3:0] ev;
        int d;
        ev = '0;
        for (int i = 0; i < 4; i++) begin
            if (m_deb[i]) begin
                d = cyc - m_rise[i];
                if (d == 0) ev[i] = 1'b1;
                else if (MASK[i] && d >= RD && ((d - RD) % RR) == 0) ev[i] = 1'b1;
            end
        end
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0; m_pend = '0; m_op = '0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
        end else begin
            if (draw) begin
                m_op   = m_pend | ev;
                m_pend = '0;
            end else begin
                m_op   = '0;
                m_pend = m_pend | ev;
            end
            for (int i = 0; i < 4; i++) begin
                if (m_s2[i] != m_deb[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_deb[i] = m_s2[i];
                        m_run[i] = 0;
                        if (m_deb[i]) m_rise[i] = cyc + 1;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = raw;
        end
        cyc++;
    endtask

    task automatic tick();
        @(posedge vga_clk);
        model_edge();
        #1;
    endtask

    task automatic settle();
        rst = 1'b1; raw = '0; draw = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; raw = 4'b1111; draw = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (op_keys !== 4'b0000 || keys_held !== 4'b0000) begin
                miscompares++;
                $display("FAIL reset_hold op=%b held=%b required op=0000 held=0000", op_keys, keys_held);
            end
        end
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            vectors++;
            if (keys_held !== ((k == 6) ? 4'b1111 : 4'b0000) || op_keys !== m_op) begin
                miscompares++;
                $display("FAIL reset_release k=%0d held=%b op=%b required held=%b op=%b",
                         k, keys_held, op_keys, (k == 6) ? 4'b1111 : 4'b0000, m_op);
            end
        end
        draw = 1'b1;
        tick();
        vectors++;
        if (op_keys !== 4'b1111 || op_keys !== m_op) begin
            miscompares++;
            $display("FAIL reset_first_frame op=%b required 1111", op_keys);
        end
        draw = 1'b0;
        tick();
        vectors++;
        if (op_keys !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_pulse_width op=%b required 0000", op_keys);
        end
    endtask

    task automatic test_bounce();
        int k;
        int pulses;
        logic [3:0] last_op;
        settle();
        raw = 4'b0100; tick();
        raw = 4'b0000; tick();
        raw = 4'b0100; tick();
        raw = 4'b0000; tick();
        raw = 4'b0100;
        k = 0;
        while (!keys_held[2] && k < 20) begin
            tick();
            k++;
            vectors++;
            if (keys_held !== m_deb || op_keys !== m_op) begin
                miscompares++;
                $display("FAIL bounce_model held=%b op=%b required held=%b op=%b", keys_held, op_keys, m_deb, m_op);
            end
        end
        vectors++;
        if (k != 6) begin
            miscompares++;
            $display("FAIL bounce_latency cycles=%0d required 6", k);
        end
        pulses = 0; last_op = '0;
        for (int f = 0; f < 50; f++) begin
            draw = (f == 48);
            tick();
            if (op_keys !== 4'b0000) begin pulses++; last_op = op_keys; end
        end
        draw = 1'b0;
        vectors++;
        if (pulses != 1 || last_op !== 4'b0100) begin
            miscompares++;
            $display("FAIL bounce_pulse count=%0d op=%b required count=1 op=0100", pulses, last_op);
        end
    endtask

    task automatic test_repeat();
        int k;
        logic exp;
        settle();
        raw = 4'b1000;
        k = 0;
        while (!keys_held[3] && k < 20) begin tick(); k++; end
        vectors++;
        if (!keys_held[3]) begin
            miscompares++;
            $display("FAIL repeat_press_timeout held=%b required held[3]=1", keys_held);
        end
        draw = 1'b1;
        for (int rel = 1; rel <= 44; rel++) begin
            tick();
            exp = (rel == 1) || (rel >= 11 && ((rel - 11) % 5) == 0);
            vectors++;
            if (op_keys[3] !== exp || op_keys !== m_op) begin
                miscompares++;
                $display("FAIL repeat_pulse rel=%0d op=%b required op[3]=%b model=%b", rel, op_keys, exp, m_op);
            end
        end
        draw = 1'b0;
    endtask

    task automatic test_no_repeat_up();
        int pulses;
        settle();
        raw = 4'b0001;
        pulses = 0;
        for (int k = 0; k < 200; k++) begin
            draw = ((k % 50) == 49);
            tick();
            if (op_keys[0]) pulses++;
            vectors++;
            if (op_keys !== m_op || keys_held !== m_deb) begin
                miscompares++;
                $display("FAIL up_model k=%0d op=%b held=%b required op=%b held=%b", k, op_keys, keys_held, m_op, m_deb);
            end
        end
        draw = 1'b0;
        vectors++;
        if (pulses != 1) begin
            miscompares++;
            $display("FAIL up_single_pulse count=%0d required 1", pulses);
        end
    endtask

    task automatic test_coincidence();
        int k;
        int pulses;
        settle();
        raw = 4'b0010;
        k = 0;
        while (!keys_held[1] && k < 20) begin tick(); k++; end
        raw = 4'b0000;
        draw = 1'b1;
        tick();
        vectors++;
        if (op_keys !== 4'b0010) begin
            miscompares++;
            $display("FAIL coincide_pulse op=%b required 0010", op_keys);
        end
        pulses = 0;
        for (int f = 0; f < 50; f++) begin
            draw = (f == 48);
            tick();
            if (op_keys !== 4'b0000) pulses++;
        end
        draw = 1'b0;
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("FAIL coincide_second_frame count=%0d required 0", pulses);
        end
    endtask

    task automatic test_release();
        int k;
        int pulses;
        settle();
        raw = 4'b0010;
        k = 0;
        while (!keys_held[1] && k < 20) begin tick(); k++; end
        tick(); tick();
        raw = 4'b0000;
        k = 0;
        while (keys_held[1] && k < 20) begin tick(); k++; end
        vectors++;
        if (k != 6) begin
            miscompares++;
            $display("FAIL release_latency cycles=%0d required 6", k);
        end
        pulses = 0;
        for (int f = 0; f < 60; f++) begin
            draw = ((f % 20) == 19);
            tick();
            if (op_keys[1]) pulses++;
        end
        draw = 1'b0;
        vectors++;
        if (pulses != 1) begin
            miscompares++;
            $display("FAIL release_no_repeat count=%0d required 1", pulses);
        end
    endtask

    task automatic test_random();
        settle();
        for (int k = 0; k < 4000; k++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 19) == 0) raw[i] = ~raw[i];
            draw = ($urandom_range(0, 9) == 0);
            rst  = ($urandom_range(0, 499) == 0);
            tick();
            vectors++;
            if (op_keys !== m_op || keys_held !== m_deb) begin
                miscompares++;
                $display("FAIL random k=%0d op=%b held=%b required op=%b held=%b", k, op_keys, keys_held, m_op, m_deb);
            end
        end
        rst = 1'b0; draw = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_repeat();
        test_no_repeat_up();
        test_coincidence();
        test_release();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
